// File: rtl/inst_mem_loader.sv
// Instruction-memory writer: packs a little-endian byte stream into 32-bit words at addresses 0..N-1, holding the CPU in reset until done.
// Optional macro LOADER_CHECKSUM_EN adds a running byte sum and a trailer byte that must zero it before the CPU is released.
module inst_mem_loader #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [7:0]        checksum
);
    typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_TRAIL, S_DONE} state_t;

    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_byte_cnt;
    logic [ADDR_W:0]   r_word_cnt;
    logic [ADDR_W:0]   r_target;
    logic [23:0]       r_asm;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              w_accept;
    logic              w_start_ok;
    logic              w_last_word;
    logic [ADDR_W:0]   w_target;

    assign w_accept    = byte_valid && byte_ready;
    assign w_start_ok  = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last_word = (r_word_cnt == r_target - 1'b1);
    assign w_target    = (num_words > LP_DEPTH) ? LP_DEPTH : num_words;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

    always_comb begin
        w_next     = r_state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) w_next = (num_words == '0) ? S_DONE : S_RECV;
            end
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_accept && r_byte_cnt == 2'd3) w_next = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
                if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    w_next = S_TRAIL;
`else
                    w_next = S_DONE;
`endif
                end else begin
                    w_next = S_RECV;
                end
            end
            S_TRAIL: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_target   <= '0;
            r_asm      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_byte_cnt <= '0;
                r_word_cnt <= '0;
                r_target   <= w_target;
            end else begin
                if (r_state == S_RECV && w_accept) begin
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    // Address/data are registered on the 4th byte so they hold after the write pulse.
                    case (r_byte_cnt)
                        2'd0:    r_asm[7:0]   <= byte_in;
                        2'd1:    r_asm[15:8]  <= byte_in;
                        2'd2:    r_asm[23:16] <= byte_in;
                        default: begin
                            r_addr  <= r_word_cnt[ADDR_W-1:0];
                            r_wdata <= {byte_in, r_asm};
                        end
                    endcase
                end
                if (r_state == S_WRITE && !w_last_word) r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_sum_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum    <= '0;
            r_sum_ok <= 1'b0;
        end else if (w_start_ok) begin
            r_sum    <= '0;
            r_sum_ok <= (num_words == '0);
        end else if (r_state == S_RECV && w_accept) begin
            r_sum <= r_sum + byte_in;
        end else if (r_state == S_TRAIL && w_accept) begin
            r_sum_ok <= ((r_sum + byte_in) == 8'd0);
        end
    end

    assign checksum = r_sum;
    assign cpu_hold = !(r_state == S_DONE && r_sum_ok);
`else
    assign checksum = '0;
    assign cpu_hold = (r_state != S_DONE);
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
`timescale 1ns/1ps
module tb_inst_mem_loader;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_words = '0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              cpu_hold;
    logic [7:0]        checksum;

    inst_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .cpu_hold(cpu_hold), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words  [DEPTH];
    logic [31:0] tb_mem [DEPTH];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every write pulse must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), e.addr);
                chk("wr_data", mem_wdata, e.data);
            end
            tb_mem[mem_addr] = mem_wdata;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        while (!acc && guard < 50) begin
            @(negedge clk);
            if (byte_ready) acc = 1'b1;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) chk("byte_accept_timeout", 32'd0, 32'd1);
        byte_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_mem_we"},     32'(mem_we),     32'd0);
        chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        chk({tag, "_mem_wdata"},  mem_wdata,       32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
        chk({tag, "_checksum"},   32'(checksum),   32'd0);
    endtask

    // Reference: target = min(n, DEPTH); words[0..target-1] land at addresses 0..target-1;
    // each word costs 4 accepts + 1 write cycle plus any source gaps, plus one trailer cycle when enabled.
    task automatic run_load(input int n, input bit gaps_on, input bit force_trl, input logic [7:0] trl_val);
        int         tgt, gsum, t0, lat, g, exp_lat;
        int         gap[4];
        logic [7:0] sum, trl, res;
        bit         exp_hold;
        tgt  = (n > DEPTH) ? DEPTH : n;
        sum  = 8'd0;
        gsum = 0;
        for (int i = 0; i < tgt; i++) begin
            exp_q.push_back(wr_t'{addr: 32'(i), data: words[i]});
            for (int b = 0; b < 4; b++) sum = sum + words[i][8*b +: 8];
        end
        trl = force_trl ? trl_val : (8'd0 - sum);

        start     = 1'b1;
        num_words = (ADDR_W+1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        t0    = cyc;
        chk("busy_after_start", 32'(busy), 32'(tgt > 0));
        chk("done_after_start", 32'(done), 32'(tgt == 0));

        for (int i = 0; i < tgt; i++) begin
            gap = '{default: 0};
            if (gaps_on) begin
                repeat (3) gap[$urandom_range(1, 3)]++;
                gsum += 3;
            end
            for (int b = 0; b < 4; b++) begin
                repeat (gap[b]) begin
                    byte_valid = 1'b0;
                    byte_in    = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
                send_byte(words[i][8*b +: 8]);
            end
        end
        if (CK_EN && tgt > 0) send_byte(trl);

        g = 0;
        while (!done && g < 50) begin
            @(negedge clk);
            g++;
        end
        lat     = cyc - t0;
        exp_lat = (tgt == 0) ? 0 : (5 * tgt + gsum + int'(CK_EN));
        res      = trl + sum;
        exp_hold = CK_EN && (tgt > 0) && (res != 8'd0);
        chk("done_latency", 32'(lat), 32'(exp_lat));
        chk("done_level",   32'(done), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("ready_at_done", 32'(byte_ready), 32'd0);
        chk("cpu_hold_at_done", 32'(cpu_hold), 32'(exp_hold));
        chk("checksum_at_done", 32'(checksum), CK_EN ? 32'(sum) : 32'd0);
        chk("writes_outstanding", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) words[i] = $urandom;
    endtask

    initial begin
        // Reset, then idle with no start.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_cpu_hold", 32'(cpu_hold), 32'd1);
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_ready", 32'(byte_ready), 32'd0);
            chk("idle_we", 32'(mem_we), 32'd0);
        end
        @(posedge clk);
        #1;

        words[0] = 32'd17; words[1] = 32'd9; words[2] = 32'd25; words[3] = 32'd55; words[4] = 32'd40;
        run_load(5, 1'b0, 1'b0, 8'd0);
        chk("mem_read_addr2", tb_mem[2], 32'd25);

        fill_random(5);
        run_load(5, 1'b1, 1'b0, 8'd0);

        run_load(0, 1'b0, 1'b0, 8'd0);

        fill_random(DEPTH);
        run_load(100, 1'b0, 1'b0, 8'd0);
        chk("mem_read_addr63", tb_mem[63], words[63]);

        // Abandon a load partway through the third word.
        fill_random(5);
        exp_q.push_back(wr_t'{addr: 32'd0, data: words[0]});
        exp_q.push_back(wr_t'{addr: 32'd1, data: words[1]});
        start     = 1'b1;
        num_words = 7'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int b = 0; b < 4; b++) send_byte(words[i][8*b +: 8]);
        send_byte(words[2][7:0]);
        send_byte(words[2][15:8]);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_no_writes", 32'(exp_q.size()), 32'd0);
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        fill_random(3);
        run_load(3, 1'b0, 1'b0, 8'd0);

        if (CK_EN) begin
            words[0] = 32'h0000_0011;
            run_load(1, 1'b0, 1'b1, 8'hEF);
            run_load(1, 1'b0, 1'b1, 8'h00);
        end

        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, 8);
            fill_random(n);
            run_load(n, 1'($urandom_range(0, 1)), 1'b0, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
Writer side of the instruction memory. Accepts a byte stream over a valid/ready handshake and packs each 4 bytes little-endian into a 32-bit word. Writes each word into instruction memory at consecutive word addresses starting from 0. Holds the CPU in reset until the programmed word count has been written, then releases it so fetch can read the memory.

Parameters:
ADDR_W, 6, word-address width; matches the instruction memory address port.
DEPTH, 64, number of words in the instruction memory (2**ADDR_W).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load (sampled only in IDLE or DONE)
num_words  input  ADDR_W+1  number of words to load, sampled on start
byte_in  input  8  stream data byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write enable, one-cycle pulse
mem_addr  output  ADDR_W  word address for the write
mem_wdata  output  32  word to write
busy  output  1  load in progress (RECV or WRITE)
done  output  1  load complete; held until next start
cpu_hold  output  1  keeps the CPU in reset while 1
checksum  output  8  running byte sum (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_hold=1, checksum=0.
  - Internal byte and word counters are cleared.
- A reset during a load abandons it. Words already written stay in memory; the loader never clears memory.
- FSM states:
  - IDLE: byte_ready=0, cpu_hold=1.
    - start with num_words==0 -> DONE.
    - start otherwise -> RECV, latching the word target as min(num_words, DEPTH).
  - RECV: byte_ready=1.
    - A byte is accepted when byte_valid && byte_ready.
    - Byte k (k=0..3) is placed in bits 8k+7:8k of the assembly register.
    - The 4th accepted byte -> WRITE on the next edge. Cycles without byte_valid are wait states with no timeout.
  - WRITE: single cycle; byte_ready=0, mem_we=1, mem_addr=word counter, mem_wdata=assembled word.
    - Next edge: if word counter == target-1 -> DONE, else word counter+1 and -> RECV.
  - DONE: done=1, cpu_hold=0, busy=0, byte_ready=0.
    - start -> clear counters and done, then behave as start from IDLE (reload).
- start in RECV/WRITE is ignored.
- Latency:
  - Minimum 5 cycles per word (4 accept cycles + 1 write cycle).
  - done rises on the edge after the last WRITE cycle.
- Word counter is ADDR_W+1 bits so target=DEPTH ends at address DEPTH-1 with no wrap.
- byte_valid while byte_ready=0 is not consumed; the source must hold data until accepted.
- mem_addr and mem_wdata hold their last values outside WRITE; only mem_we qualifies them.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - checksum is an 8-bit modulo-256 sum of every accepted byte since the last start. It is cleared on start and on reset, and is stable once done=1.
  - The loader samples one extra trailer byte after the last WRITE (RECV-like, byte_ready=1) before DONE.
  - If trailer + checksum != 0 mod 256, done is still asserted but cpu_hold stays 1.
- Not defined: checksum is tied to 0, there is no trailer byte, and cpu_hold releases at DONE.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, release -> cpu_hold=1, done=0, byte_ready=0, mem_we=0 for 10 cycles with no start.
- Load 5 words (17, 9, 25, 55, 40) as little-endian bytes with byte_valid continuously high -> mem_we pulses at addr 0..4 with those values, 25 cycles start-to-done, then done=1 and cpu_hold=0; a read of addr 2 gives 25.
- Backpressure gaps: drop byte_valid for 3 random cycles inside each word -> same writes, done delayed by exactly the gap count, no duplicated or dropped bytes.
- num_words=0 -> done=1 one cycle after start, no mem_we; num_words=100 -> exactly 64 writes, last at addr 63.
- Reset mid-load: assert rst_n=0 after byte 2 of word 3 -> outputs return to reset values, no further mem_we; a fresh start reloads from addr 0.
- LOADER_CHECKSUM_EN, bytes 0x11,0,0,0 with trailer 0xEF -> checksum=0x11, done=1, cpu_hold=0; trailer 0x00 -> done=1, cpu_hold=1.
